// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: MEM-stage load/store controller that issues one held cache request per latched instruction.
// Optional no-hit watchdog is compiled in when MEM_REQ_TIMEOUT_EN is defined.
module mem_req_ctrl #(
    parameter int unsigned TIMEOUT_MAX = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  func3,
    input  logic        halt,
    input  logic        adv,
    input  logic        cache_hit,
    input  logic [31:0] cache_rdata,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    output logic [3:0]  dmembe,
    output logic        dhit,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        misalign,
    output logic        timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic        served_q, served_d;
    logic        misalign_q, misalign_d;
    logic        ren_q, ren_d;
    logic        wen_q, wen_d;
    logic [31:0] maddr_q, maddr_d;
    logic [31:0] mstore_q, mstore_d;
    logic [3:0]  mbe_q, mbe_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] ld_q, ld_d;

    logic        want_s;
    logic        aligned_s;
    logic        issue_s;
    logic        mis_ev_s;
    logic        hit_s;
    logic        abort_s;
    logic        finish_s;

    function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] off);
        logic ok;
        case (f3[1:0])
            2'b00:   ok = 1'b1;
            2'b01:   ok = (off[0] == 1'b0);
            default: ok = (off == 2'b00);
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (f3[1:0])
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'b00:   b = w[7:0];
            2'b01:   b = w[15:8];
            2'b10:   b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'h000000, b};
            3'b101:  r = {16'h0000, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // served blocks re-issue of an instruction that is still sitting in the latch
    assign want_s    = (dREN | dWEN) & ~halt & ~served_q;
    assign aligned_s = is_aligned(func3, addr[1:0]);
    assign issue_s   = (state_q == IDLE) & want_s & aligned_s;
    assign mis_ev_s  = (state_q == IDLE) & want_s & ~aligned_s;
    assign hit_s     = (state_q == BUSY) & cache_hit;
    assign finish_s  = hit_s | abort_s;

`ifdef MEM_REQ_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_MAX - 32'd1);

    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;

    assign abort_s = (state_q == BUSY) & ~cache_hit & (cnt_q == TO_LAST);

    // Watchdog next-state: count BUSY cycles, keep timeout sticky
    always_comb begin
        cnt_d     = 8'd0;
        timeout_d = timeout_q | abort_s;
        if ((state_q == BUSY) && !finish_s) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = 8'd0;
        end
    end

    // Watchdog registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_timeout_max_s;
    assign unused_timeout_max_s = (TIMEOUT_MAX == 32'd0);
    assign abort_s = 1'b0;
    assign timeout = 1'b0;
`endif

    // Request FSM next-state, request capture and load formatting
    always_comb begin
        state_d    = state_q;
        served_d   = served_q;
        misalign_d = misalign_q;
        ren_d      = ren_q;
        wen_d      = wen_q;
        maddr_d    = maddr_q;
        mstore_d   = mstore_q;
        mbe_d      = mbe_q;
        off_d      = off_q;
        f3_d       = f3_q;
        ld_d       = ld_q;
        case (state_q)
            IDLE: begin
                if (issue_s) begin
                    state_d  = BUSY;
                    ren_d    = dREN & ~dWEN;
                    wen_d    = dWEN;
                    maddr_d  = {addr[31:2], 2'b00};
                    mstore_d = lane_data(func3, wdata);
                    mbe_d    = lane_be(func3, addr[1:0]);
                    off_d    = addr[1:0];
                    f3_d     = func3;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (finish_s) begin
                    state_d  = DONE;
                    ren_d    = 1'b0;
                    wen_d    = 1'b0;
                    maddr_d  = 32'd0;
                    mstore_d = 32'd0;
                    mbe_d    = 4'd0;
                    if (abort_s) begin
                        ld_d = 32'd0;
                    end else if (ren_q) begin
                        ld_d = fmt_load(f3_q, off_q, cache_rdata);
                    end else begin
                        ld_d = ld_q;
                    end
                end else begin
                    state_d = BUSY;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                ren_d    = 1'b0;
                wen_d    = 1'b0;
                maddr_d  = 32'd0;
                mstore_d = 32'd0;
                mbe_d    = 4'd0;
            end
        endcase
        // adv takes priority so the next instruction can issue right away
        if (adv) begin
            served_d   = 1'b0;
            misalign_d = 1'b0;
        end else if (finish_s || mis_ev_s) begin
            served_d   = 1'b1;
            misalign_d = misalign_q | mis_ev_s;
        end else begin
            served_d   = served_q;
            misalign_d = misalign_q;
        end
    end

    // State and request registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            served_q   <= 1'b0;
            misalign_q <= 1'b0;
            ren_q      <= 1'b0;
            wen_q      <= 1'b0;
            maddr_q    <= 32'd0;
            mstore_q   <= 32'd0;
            mbe_q      <= 4'd0;
            off_q      <= 2'd0;
            f3_q       <= 3'd0;
            ld_q       <= 32'd0;
        end else begin
            state_q    <= state_d;
            served_q   <= served_d;
            misalign_q <= misalign_d;
            ren_q      <= ren_d;
            wen_q      <= wen_d;
            maddr_q    <= maddr_d;
            mstore_q   <= mstore_d;
            mbe_q      <= mbe_d;
            off_q      <= off_d;
            f3_q       <= f3_d;
            ld_q       <= ld_d;
        end
    end

    assign dmemREN   = ren_q;
    assign dmemWEN   = wen_q;
    assign dmemaddr  = maddr_q;
    assign dmemstore = mstore_q;
    assign dmembe    = mbe_q;
    assign dhit      = (state_q == DONE);
    assign stall     = (state_q == BUSY) | issue_s;
    assign load_data = ld_q;
    assign misalign  = misalign_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl: directed accesses checked against a transaction-level model every cycle.
module tb_mem_req_ctrl;
`ifdef MEM_REQ_TIMEOUT_EN
    localparam int unsigned TMAX = 4;
`else
    localparam int unsigned TMAX = 255;
`endif

    logic        CLK = 1'b0;
    logic        RST, dREN, dWEN, halt, adv, cache_hit;
    logic [31:0] addr, wdata, cache_rdata;
    logic [2:0]  func3;
    logic        dmemREN, dmemWEN, dhit, stall, misalign, timeout;
    logic [31:0] dmemaddr, dmemstore, load_data;
    logic [3:0]  dmembe;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // model state: one outstanding transaction plus completion flags
    logic        m_out, m_fin, m_served, m_mis, m_to, m_ren, m_wen;
    logic [31:0] m_a, m_wd, m_ld;
    logic [2:0]  m_f3;
    int          m_cnt;

    mem_req_ctrl #(.TIMEOUT_MAX(TMAX)) dut (
        .CLK(CLK), .RST(RST), .dREN(dREN), .dWEN(dWEN), .addr(addr), .wdata(wdata),
        .func3(func3), .halt(halt), .adv(adv), .cache_hit(cache_hit), .cache_rdata(cache_rdata),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .dmembe(dmembe), .dhit(dhit), .stall(stall), .load_data(load_data),
        .misalign(misalign), .timeout(timeout)
    );

    always #5 CLK = ~CLK;

    function automatic int unsigned f_size(input logic [2:0] f3);
        return (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
    endfunction

    function automatic bit f_aligned(input logic [2:0] f3, input logic [31:0] a);
        return (a % f_size(f3)) == 0;
    endfunction

    function automatic logic [3:0] f_be(input logic [2:0] f3, input logic [31:0] a);
        int unsigned lanes;
        lanes = (32'd1 << f_size(f3)) - 32'd1;
        return 4'(lanes << int'(a[1:0]));
    endfunction

    function automatic logic [31:0] f_store(input logic [2:0] f3, input logic [31:0] wd);
        if (f_size(f3) == 1) return 32'(wd[7:0]) * 32'h0101_0101;
        if (f_size(f3) == 2) return 32'(wd[15:0]) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v, mask;
        int bits;
        if (f_size(f3) == 4) return rd;
        bits = 8 * int'(f_size(f3));
        mask = (32'd1 << bits) - 32'd1;
        v = (rd >> (8 * int'(a[1:0]))) & mask;
        if (!f3[2] && v[bits-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_step();
        logic nf;
        nf = 1'b0;
        if (RST) begin
            m_out = 1'b0; m_fin = 1'b0; m_served = 1'b0; m_mis = 1'b0; m_to = 1'b0;
            m_ren = 1'b0; m_wen = 1'b0; m_a = 32'd0; m_wd = 32'd0; m_ld = 32'd0;
            m_f3 = 3'd0; m_cnt = 0;
        end else begin
            if (m_out) begin
                if (cache_hit) begin
                    if (m_ren) m_ld = f_load(m_f3, m_a, cache_rdata);
                    m_out = 1'b0; nf = 1'b1; m_served = 1'b1;
                end else begin
                    m_cnt++;
`ifdef MEM_REQ_TIMEOUT_EN
                    if (m_cnt >= TMAX) begin
                        m_out = 1'b0; nf = 1'b1; m_served = 1'b1; m_ld = 32'd0; m_to = 1'b1;
                    end
`endif
                end
            end else if (!m_fin && !m_served && (dREN || dWEN) && !halt) begin
                if (f_aligned(func3, addr)) begin
                    m_out = 1'b1; m_cnt = 0; m_ren = dREN && !dWEN; m_wen = dWEN;
                    m_a = addr; m_wd = wdata; m_f3 = func3;
                end else begin
                    m_mis = 1'b1; m_served = 1'b1;
                end
            end
            if (adv) begin
                m_served = 1'b0; m_mis = 1'b0;
            end
            m_fin = nf;
        end
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            model_step();
        end
    end

    // per-cycle comparison against the model
    initial begin
        logic        e_stall;
        forever begin
            @(negedge CLK);
            if (chk_en) begin
                e_stall = m_out || (!m_out && !m_fin && !m_served && (dREN || dWEN) && !halt
                                    && f_aligned(func3, addr));
                chk("cyc_ren", 32'(dmemREN), 32'(m_out & m_ren));
                chk("cyc_wen", 32'(dmemWEN), 32'(m_out & m_wen));
                chk("cyc_addr", dmemaddr, m_out ? (m_a & 32'hFFFF_FFFC) : 32'd0);
                chk("cyc_store", dmemstore, m_out ? f_store(m_f3, m_wd) : 32'd0);
                chk("cyc_be", 32'(dmembe), m_out ? 32'(f_be(m_f3, m_a)) : 32'd0);
                chk("cyc_dhit", 32'(dhit), 32'(m_fin));
                chk("cyc_stall", 32'(stall), 32'(e_stall));
                chk("cyc_load", load_data, m_ld);
                chk("cyc_misalign", 32'(misalign), 32'(m_mis));
                chk("cyc_timeout", 32'(timeout), 32'(m_to));
            end
        end
    end

    task automatic access(input logic ren, input logic wen, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] f3, input int dly, input logic [31:0] rd, input logic adv_done,
                          input logic [31:0] e_addr, input logic [31:0] e_store, input logic [3:0] e_be,
                          input logic [31:0] e_ld);
        dREN = ren; dWEN = wen; addr = a; wdata = wd; func3 = f3;
        halt = 1'b0; adv = 1'b0; cache_hit = 1'b0;
        tick();
        @(negedge CLK);
        chk("req_addr", dmemaddr, e_addr);
        chk("req_store", dmemstore, e_store);
        chk("req_be", 32'(dmembe), 32'(e_be));
        chk("req_wen", 32'(dmemWEN), 32'(wen));
        chk("req_stall", 32'(stall), 32'd1);
        repeat (dly) tick();
        cache_hit = 1'b1; cache_rdata = rd;
        tick();
        cache_hit = 1'b0;
        @(negedge CLK);
        chk("done_dhit", 32'(dhit), 32'd1);
        chk("done_stall", 32'(stall), 32'd0);
        chk("done_load", load_data, e_ld);
        adv = adv_done;
        tick();
        adv = 1'b0;
    endtask

    initial begin
        RST = 1'b1; dREN = 1'b0; dWEN = 1'b0; halt = 1'b0; adv = 1'b0; cache_hit = 1'b0;
        addr = 32'd0; wdata = 32'd0; cache_rdata = 32'd0; func3 = 3'd0;
        tick();
        chk_en = 1'b1;
        tick();
        @(negedge CLK);
        chk("rst_ren", 32'(dmemREN), 32'd0);
        chk("rst_wen", 32'(dmemWEN), 32'd0);
        chk("rst_be", 32'(dmembe), 32'd0);
        chk("rst_addr", dmemaddr, 32'd0);
        chk("rst_load", load_data, 32'd0);
        chk("rst_dhit", 32'(dhit), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        RST = 1'b0;

        access(1'b1, 1'b0, 32'h104, 32'h0, 3'b010, 2, 32'hDEADBEEF, 1'b1, 32'h104, 32'h0, 4'hF, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'h103, 32'h0, 3'b000, 1, 32'h80112233, 1'b1, 32'h100, 32'h0, 4'h8, 32'hFFFFFF80);
        access(1'b1, 1'b0, 32'h103, 32'h0, 3'b100, 1, 32'h80112233, 1'b1, 32'h100, 32'h0, 4'h8, 32'h00000080);
        access(1'b1, 1'b0, 32'h102, 32'h0, 3'b001, 0, 32'h80017FFF, 1'b1, 32'h100, 32'h0, 4'hC, 32'hFFFF8001);
        access(1'b1, 1'b0, 32'h100, 32'h0, 3'b101, 1, 32'h80017FFF, 1'b1, 32'h100, 32'h0, 4'h3, 32'h00007FFF);
        access(1'b0, 1'b1, 32'h202, 32'h0000ABCD, 3'b001, 3, 32'h0, 1'b1, 32'h200, 32'hABCDABCD, 4'hC, 32'h00007FFF);
        access(1'b0, 1'b1, 32'h301, 32'h12345677, 3'b000, 0, 32'h0, 1'b1, 32'h300, 32'h77777777, 4'h2, 32'h00007FFF);
        access(1'b1, 1'b1, 32'h400, 32'hCAFEF00D, 3'b010, 1, 32'h11111111, 1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 32'h00007FFF);

        // latch held after completion: no second request
        access(1'b1, 1'b0, 32'h500, 32'h0, 3'b010, 0, 32'h13579BDF, 1'b0, 32'h500, 32'h0, 4'hF, 32'h13579BDF);
        repeat (10) tick();
        @(negedge CLK);
        chk("held_noreq", 32'({dmemREN, dmemWEN}), 32'd0);
        chk("held_nodhit", 32'(dhit), 32'd0);
        adv = 1'b1;
        tick();
        access(1'b1, 1'b0, 32'h504, 32'h0, 3'b010, 0, 32'h2468ACE0, 1'b1, 32'h504, 32'h0, 4'hF, 32'h2468ACE0);

        // halt blocks issue; halt rising in BUSY does not abort
        dREN = 1'b1; dWEN = 1'b0; addr = 32'h600; func3 = 3'b010; halt = 1'b1;
        repeat (3) tick();
        @(negedge CLK);
        chk("halt_noreq", 32'(dmemREN), 32'd0);
        chk("halt_nostall", 32'(stall), 32'd0);
        halt = 1'b0;
        tick();
        halt = 1'b1;
        @(negedge CLK);
        chk("halt_busy_ren", 32'(dmemREN), 32'd1);
        cache_hit = 1'b1; cache_rdata = 32'h0BADF00D;
        tick();
        cache_hit = 1'b0;
        @(negedge CLK);
        chk("halt_dhit", 32'(dhit), 32'd1);
        chk("halt_load", load_data, 32'h0BADF00D);
        adv = 1'b1;
        tick();
        adv = 1'b0; dREN = 1'b0; halt = 1'b0;

        // misaligned SW then misaligned LH
        dWEN = 1'b1; addr = 32'h101; func3 = 3'b010; wdata = 32'h55AA55AA;
        repeat (2) tick();
        @(negedge CLK);
        chk("mis_flag", 32'(misalign), 32'd1);
        chk("mis_nowen", 32'(dmemWEN), 32'd0);
        chk("mis_nodhit", 32'(dhit), 32'd0);
        adv = 1'b1;
        tick();
        adv = 1'b0; dWEN = 1'b0; dREN = 1'b1; addr = 32'h103; func3 = 3'b001;
        @(negedge CLK);
        chk("mis_clr", 32'(misalign), 32'd0);
        tick();
        @(negedge CLK);
        chk("mis_lh", 32'(misalign), 32'd1);
        adv = 1'b1; dREN = 1'b0;
        tick();
        adv = 1'b0;

        // stray cache_hit while idle
        cache_hit = 1'b1; cache_rdata = 32'hFFFFFFFF;
        repeat (2) tick();
        cache_hit = 1'b0;
        @(negedge CLK);
        chk("idle_hit_dhit", 32'(dhit), 32'd0);
        chk("idle_hit_load", load_data, 32'h0BADF00D);

`ifdef MEM_REQ_TIMEOUT_EN
        dREN = 1'b1; addr = 32'h700; func3 = 3'b010;
        tick();
        repeat (4) tick();
        @(negedge CLK);
        chk("to_dhit", 32'(dhit), 32'd1);
        chk("to_flag", 32'(timeout), 32'd1);
        chk("to_load", load_data, 32'd0);
        adv = 1'b1;
        tick();
        adv = 1'b0; dREN = 1'b0;
        @(negedge CLK);
        chk("to_sticky", 32'(timeout), 32'd1);
`endif

        // reset while BUSY aborts the request
        dREN = 1'b1; addr = 32'h800; func3 = 3'b010;
        tick();
        @(negedge CLK);
        chk("rstb_ren", 32'(dmemREN), 32'd1);
        tick();
        RST = 1'b1; dREN = 1'b0;
        tick();
        RST = 1'b0;
        @(negedge CLK);
        chk("rstb_ren0", 32'(dmemREN), 32'd0);
        chk("rstb_addr0", dmemaddr, 32'd0);
        chk("rstb_be0", 32'(dmembe), 32'd0);
        chk("rstb_dhit0", 32'(dhit), 32'd0);
        chk("rstb_load0", load_data, 32'd0);
        chk("rstb_to0", 32'(timeout), 32'd0);
        cache_hit = 1'b1;
        repeat (2) tick();
        cache_hit = 1'b0;
        @(negedge CLK);
        chk("rstb_nodhit", 32'(dhit), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
